store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries; power of two, 2..16.
REQ-002 SHALL have parameter AW, default 32, address width in bits.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port sb_push, input, 1, ROB commits a store this cycle.
REQ-006 SHALL have port sb_addr, input, AW, byte address of the committed store.
REQ-007 SHALL have port sb_data, input, 32, store data; a byte store uses bits [7:0].
REQ-008 SHALL have port sb_byte, input, 1, 1 = byte store, 0 = word store.
REQ-009 SHALL have port sb_full, output, 1, count == DEPTH; the tail stage stalls commit of stores.
REQ-010 SHALL have port sb_empty, output, 1, count == 0.
REQ-011 SHALL have port dc_wr_valid, output, 1, head entry offered to dcache.
REQ-012 SHALL have ports dc_wr_addr (AW), dc_wr_data (32) and dc_wr_byte (1), all outputs, carrying the head entry's fields.
REQ-013 SHALL have port dc_wr_ready, input, 1, dcache accepts the write this cycle.
REQ-014 SHALL have ports ld_req (1), ld_addr (AW) and ld_byte (1), all inputs, carrying the ALU-stage load lookup.
REQ-015 SHALL have ports ld_hit (1), ld_data (32) and ld_conflict (1), all outputs, returning the forwarding result combinationally in the same cycle as the lookup.

Function
REQ-016 SHALL be a circular FIFO with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
REQ-017 SHALL write {addr, data, byte} at the tail and advance the tail when sb_push=1 and sb_full=0.
REQ-018 SHALL ignore sb_push while sb_full=1, even if a pop occurs in the same cycle; no state changes due to the push.
REQ-019 SHALL drive dc_wr_valid = ~sb_empty, with dc_wr_* equal to the head entry, stable until accepted.
REQ-020 SHALL pop the head (advance head, decrement count) on the rising edge when dc_wr_valid && dc_wr_ready.
REQ-021 SHALL, on a simultaneous accepted push and pop, update both pointers and leave count unchanged.
REQ-022 SHALL make a pushed entry visible to dc_wr_* and to lookups no earlier than the cycle after the push (1-cycle latency); a push into an empty buffer gives dc_wr_valid=1 on the next cycle.
REQ-023 SHALL, for a lookup, compare ld_addr[AW-1:2] with every valid entry's addr[AW-1:2] and select the youngest matching entry (closest to the tail).
REQ-024 SHALL, when the youngest match is a word store, set ld_hit=1 and ld_data = the word for a word load, or the addressed byte zero-extended (ld_addr[1:0] selects the byte; 0 = bits [7:0]) for a byte load.
REQ-025 SHALL, when the youngest match is a byte store, a byte load and an identical full address, set ld_hit=1 and ld_data = {24'b0, data[7:0]}.
REQ-026 SHALL, when the youngest match is a byte store and the load is a word load or targets a different byte, set ld_conflict=1 and ld_hit=0; the load is stalled until the entry drains.
REQ-027 SHALL drive ld_hit=0, ld_conflict=0 and ld_data=0 when ld_req=0 or there is no match.
REQ-028 SHALL exclude from the lookup an entry being popped in the current cycle only after that edge; the lookup uses the pre-edge state.

Reset
REQ-029 SHALL, while reset=1, asynchronously clear head, tail and count and drive sb_empty=1, sb_full=0, dc_wr_valid=0, ld_hit=0 and ld_conflict=0.
REQ-030 SHALL discard all entries on reset asserted mid-drain; no dcache write is issued after reset.
REQ-031 SHALL leave entry data contents undefined after reset; they are never observable while invalid.

Verification
REQ-032 SHALL be verified for fill-and-drain: push 4 word stores (addr 0x10/0x14/0x18/0x1C, data 1..4) with dc_wr_ready=0 -> sb_full=1; 5th push dropped; ready=1 -> 4 writes issue in order, then sb_empty=1.
REQ-033 SHALL be verified for forwarding priority: push word 0x20=0xAAAA0000, then word 0x20=0x12345678; word load 0x20 -> ld_hit=1, ld_data=0x12345678; byte load 0x21 -> ld_data=0x00000056.
REQ-034 SHALL be verified for the byte conflict: push byte store 0x40=0xEF; word load 0x40 -> ld_conflict=1; byte load 0x40 -> ld_hit=1, ld_data=0xEF; after drain, word load 0x40 -> ld_hit=0, ld_conflict=0.
REQ-035 SHALL be verified for simultaneous push/pop at count=2 with ready=1 for 6 cycles -> count stays 2 and pointers wrap past DEPTH-1 without loss or reordering.
REQ-036 SHALL be verified for reset mid-operation: 3 entries held, reset pulsed 1 ns off the clock edge -> dc_wr_valid=0 and sb_empty=1 immediately, and the next push is written at index 0.

Source files
------------

// File: rtl/store_buffer_if.sv
// Bus bundle for the store buffer: ROB commit side, dcache write side and
// the ALU-stage load-forwarding lookup.
interface store_buffer_if #(
    parameter int AW = 32
);
    logic          sb_push;
    logic [AW-1:0] sb_addr;
    logic [31:0]   sb_data;
    logic          sb_byte;
    logic          sb_full;
    logic          sb_empty;

    logic          dc_wr_valid;
    logic [AW-1:0] dc_wr_addr;
    logic [31:0]   dc_wr_data;
    logic          dc_wr_byte;
    logic          dc_wr_ready;

    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic          ld_byte;
    logic          ld_hit;
    logic [31:0]   ld_data;
    logic          ld_conflict;

    modport master (
        output sb_push, sb_addr, sb_data, sb_byte, dc_wr_ready, ld_req, ld_addr, ld_byte,
        input  sb_full, sb_empty, dc_wr_valid, dc_wr_addr, dc_wr_data, dc_wr_byte,
               ld_hit, ld_data, ld_conflict
    );

    modport slave (
        input  sb_push, sb_addr, sb_data, sb_byte, dc_wr_ready, ld_req, ld_addr, ld_byte,
        output sb_full, sb_empty, dc_wr_valid, dc_wr_addr, dc_wr_data, dc_wr_byte,
               ld_hit, ld_data, ld_conflict
    );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer between ROB commit and the dcache, with youngest-match
// store-to-load forwarding for the ALU-stage load lookup.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic          r_byte [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_matchFound;
    logic [PW-1:0] w_matchIdx;
    logic [PW-1:0] w_scanIdx;
    logic          w_ldHit;
    logic          w_ldConflict;
    logic [31:0]   w_ldData;
    logic [31:0]   w_matchWord;

    assign w_full  = (r_count == (PW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.sb_push && !w_full;
    assign w_pop   = !w_empty && bus.dc_wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload is deliberately unreset; validity comes solely from head/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.sb_addr;
            r_data[r_tail] <= bus.sb_data;
            r_byte[r_tail] <= bus.sb_byte;
        end
    end

    assign bus.sb_full     = w_full;
    assign bus.sb_empty    = w_empty;
    assign bus.dc_wr_valid = !w_empty;
    assign bus.dc_wr_addr  = r_addr[r_head];
    assign bus.dc_wr_data  = r_data[r_head];
    assign bus.dc_wr_byte  = r_byte[r_head];

    // Scan oldest to youngest so the last hit recorded is the youngest match.
    always_comb begin
        w_matchFound = 1'b0;
        w_matchIdx   = '0;
        w_scanIdx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scanIdx = r_head + PW'(k);
            if (((PW+1)'(k) < r_count) &&
                (r_addr[w_scanIdx][AW-1:2] == bus.ld_addr[AW-1:2])) begin
                w_matchFound = 1'b1;
                w_matchIdx   = w_scanIdx;
            end
        end
    end

    always_comb begin
        w_ldHit      = 1'b0;
        w_ldConflict = 1'b0;
        w_ldData     = '0;
        w_matchWord  = r_data[w_matchIdx];
        if (bus.ld_req && w_matchFound) begin
            if (!r_byte[w_matchIdx]) begin
                w_ldHit = 1'b1;
                if (bus.ld_byte) begin
                    case (bus.ld_addr[1:0])
                        2'd0:    w_ldData = {24'b0, w_matchWord[7:0]};
                        2'd1:    w_ldData = {24'b0, w_matchWord[15:8]};
                        2'd2:    w_ldData = {24'b0, w_matchWord[23:16]};
                        default: w_ldData = {24'b0, w_matchWord[31:24]};
                    endcase
                end else begin
                    w_ldData = w_matchWord;
                end
            end else if (bus.ld_byte && (bus.ld_addr == r_addr[w_matchIdx])) begin
                w_ldHit  = 1'b1;
                w_ldData = {24'b0, w_matchWord[7:0]};
            end else begin
                w_ldConflict = 1'b1;
            end
        end
    end

    assign bus.ld_hit      = w_ldHit;
    assign bus.ld_data     = w_ldData;
    assign bus.ld_conflict = w_ldConflict;
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// phase, all checked against a queue-based reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        isByte;
    } entry_t;

    logic   clk = 1'b0;
    logic   reset;
    int     checks = 0;
    int     errors = 0;
    entry_t model[$];

    store_buffer_if #(.AW(AW)) sbIf ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sbIf.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic expectEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Forwarding rules computed directly from the queue: youngest entry in the same word wins.
    task automatic modelLookup(output logic expHit, output logic expConf, output logic [31:0] expData);
        expHit  = 1'b0;
        expConf = 1'b0;
        expData = 32'h0;
        if (sbIf.ld_req) begin
            for (int i = model.size() - 1; i >= 0; i--) begin
                if (model[i].addr[31:2] == sbIf.ld_addr[31:2]) begin
                    if (!model[i].isByte) begin
                        expHit  = 1'b1;
                        expData = sbIf.ld_byte ? ((model[i].data >> (8 * sbIf.ld_addr[1:0])) & 32'hFF)
                                               : model[i].data;
                    end else if (sbIf.ld_byte && model[i].addr == sbIf.ld_addr) begin
                        expHit  = 1'b1;
                        expData = model[i].data & 32'hFF;
                    end else begin
                        expConf = 1'b1;
                    end
                    break;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic push, input logic [31:0] addr, input logic [31:0] data,
                                 input logic isByte, input logic ready, input logic ldReq,
                                 input logic [31:0] ldAddr, input logic ldByte);
        sbIf.sb_push     = push;
        sbIf.sb_addr     = addr;
        sbIf.sb_data     = data;
        sbIf.sb_byte     = isByte;
        sbIf.dc_wr_ready = ready;
        sbIf.ld_req      = ldReq;
        sbIf.ld_addr     = ldAddr;
        sbIf.ld_byte     = ldByte;
        #2;
    endtask

    task automatic lookup(input logic [31:0] ldAddr, input logic ldByte);
        sbIf.ld_req  = 1'b1;
        sbIf.ld_addr = ldAddr;
        sbIf.ld_byte = ldByte;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic        expHit;
        logic        expConf;
        logic [31:0] expData;
        expectEq({tag, ":sb_full"},     32'(sbIf.sb_full),     32'(model.size() == DEPTH));
        expectEq({tag, ":sb_empty"},    32'(sbIf.sb_empty),    32'(model.size() == 0));
        expectEq({tag, ":dc_wr_valid"}, 32'(sbIf.dc_wr_valid), 32'(model.size() != 0));
        if (model.size() != 0) begin
            expectEq({tag, ":dc_wr_addr"}, sbIf.dc_wr_addr,        model[0].addr);
            expectEq({tag, ":dc_wr_data"}, sbIf.dc_wr_data,        model[0].data);
            expectEq({tag, ":dc_wr_byte"}, 32'(sbIf.dc_wr_byte),   32'(model[0].isByte));
        end
        modelLookup(expHit, expConf, expData);
        expectEq({tag, ":ld_hit"},      32'(sbIf.ld_hit),      32'(expHit));
        expectEq({tag, ":ld_conflict"}, 32'(sbIf.ld_conflict), 32'(expConf));
        expectEq({tag, ":ld_data"},     sbIf.ld_data,          expData);
    endtask

    // Model update uses the pre-edge occupancy, so a push into a full buffer is dropped even with a pop.
    task automatic advanceClock();
        bit     doPop;
        bit     doPush;
        entry_t e;
        doPop  = (model.size() != 0) && sbIf.dc_wr_ready;
        doPush = sbIf.sb_push && (model.size() < DEPTH);
        e.addr   = sbIf.sb_addr;
        e.data   = sbIf.sb_data;
        e.isByte = sbIf.sb_byte;
        if (doPop)  void'(model.pop_front());
        if (doPush) model.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
        checkOutput("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill and drain.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h10 + 32'(4 * i), 32'(i + 1), 1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
            checkOutput("fill");
            advanceClock();
        end
        applyStimulus(1'b1, 32'h20, 32'h5, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        expectEq("fill:full_const", 32'(sbIf.sb_full), 32'd1);
        checkOutput("fill5");
        advanceClock();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1C, 1'b0);
            expectEq("drain:order", sbIf.dc_wr_data, 32'(i + 1));
            checkOutput("drain");
            advanceClock();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        expectEq("drain:empty_const", 32'(sbIf.sb_empty), 32'd1);
        checkOutput("drained");

        // Forwarding priority.
        applyStimulus(1'b1, 32'h20, 32'hAAAA0000, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
        expectEq("fwd:not_yet_visible", 32'(sbIf.ld_hit), 32'd0);
        advanceClock();
        applyStimulus(1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
        expectEq("fwd:word_data", sbIf.ld_data, 32'h12345678);
        checkOutput("fwd_word");
        lookup(32'h21, 1'b1);
        expectEq("fwd:byte_data", sbIf.ld_data, 32'h00000056);
        checkOutput("fwd_byte");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            advanceClock();
        end

        // Byte-store conflict.
        applyStimulus(1'b1, 32'h40, 32'h000000EF, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        expectEq("conf:word_conflict", 32'(sbIf.ld_conflict), 32'd1);
        checkOutput("conf_word");
        lookup(32'h40, 1'b1);
        expectEq("conf:byte_data", sbIf.ld_data, 32'h000000EF);
        checkOutput("conf_byte");
        lookup(32'h41, 1'b1);
        checkOutput("conf_otherbyte");
        sbIf.dc_wr_ready = 1'b1;
        #1;
        checkOutput("conf_popping");
        advanceClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        expectEq("conf:after_drain", 32'(sbIf.ld_hit | sbIf.ld_conflict), 32'd0);
        checkOutput("conf_drained");

        // Steady push/pop at occupancy two, wrapping the pointers.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            advanceClock();
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'h208 + 32'(4 * i), 32'hC2 + 32'(i), 1'b0, 1'b1, 1'b1, 32'h200 + 32'(4 * i), 1'b0);
            expectEq("pp:head_data", sbIf.dc_wr_data, 32'hC0 + 32'(i));
            checkOutput("pushpop");
            advanceClock();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        expectEq("pp:count2", 32'(model.size()), 32'd2);
        checkOutput("pushpop_end");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            checkOutput("pp_drain");
            advanceClock();
        end

        // Randomized traffic over a small address window to provoke matches and conflicts.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 3) != 0), 32'h100 + 32'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)));
            checkOutput("random");
            advanceClock();
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            advanceClock();
        end

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'hD0 + 32'(i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            advanceClock();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
        checkOutput("pre_reset");
        reset = 1'b1;
        model.delete();
        #1;
        expectEq("rst:dc_wr_valid", 32'(sbIf.dc_wr_valid), 32'd0);
        expectEq("rst:sb_empty",    32'(sbIf.sb_empty),    32'd1);
        checkOutput("mid_reset");
        #1;
        reset = 1'b0;
        #1;
        expectEq("rst:tail_zero", 32'(dut.r_tail), 32'd0);
        checkOutput("post_reset");
        advanceClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("no_write_after_reset");
        advanceClock();
        applyStimulus(1'b1, 32'h80, 32'hBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
        expectEq("rst:slot0_addr", dut.r_addr[0], 32'h80);
        expectEq("rst:tail_one",   32'(dut.r_tail), 32'd1);
        checkOutput("first_push_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
